wt_store_wbuf: RTL and testbench
================================

# wt_store_wbuf

Write-through store buffer between the CVA6 load/store unit and the memory-side request port of the write-through data cache (`WT` cache type). It accepts word-sized stores, merges stores to the same pending word, and issues them to memory in allocation order. It tracks in-flight writes by transaction ID until they are acknowledged, and retires entries in order. It also reports address hits for load ordering.

## Interface
Parameters:
- `DEPTH`, 8: number of buffer entries (power of two, ≥2).
- `PLEN`, 34: physical address width.
- `XLEN`, 32: data width; word = `XLEN/8` bytes.
- `TID_W`, 2: memory transaction ID width; 2^`TID_W` IDs may be in flight.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock; reset is asynchronous and active-high.
- `req_valid_i` in 1: store request valid.
- `req_ready_o` out 1: buffer can accept; equals `count < DEPTH`.
- `req_addr_i` in `PLEN`: store byte address; low `log2(XLEN/8)` bits ignored.
- `req_data_i` in `XLEN`: store data, byte-lane aligned.
- `req_be_i` in `XLEN/8`: byte enables.
- `req_nc_i` in 1: non-cacheable or non-idempotent store; never merged.
- `mem_valid_o` out 1: write request to memory.
- `mem_ready_i` in 1: memory accepts request.
- `mem_addr_o` out `PLEN`: word-aligned address.
- `mem_data_o` out `XLEN`: write data.
- `mem_be_o` out `XLEN/8`: byte enables.
- `mem_tid_o` out `TID_W`: transaction ID.
- `ack_valid_i` in 1: write acknowledge.
- `ack_tid_i` in `TID_W`: ID being acknowledged.
- `ld_addr_i` in `PLEN`: load address to check.
- `ld_hit_o` out 1: some non-retired entry matches the word address of `ld_addr_i`.
- `empty_o` out 1: no entries held (`count == 0`).

## Operation
- Entry state is one of FREE, PEND, INFL or DONE. Entries sit in a circular queue with three pointers:
  - `wr_ptr`: allocate.
  - `iss_ptr`: next to issue.
  - `ret_ptr`: oldest held entry.
- `count = wr_ptr - ret_ptr`. Pointers use `log2(DEPTH)+1` bits so that full and empty can be told apart.
- Store accept occurs on `req_valid_i && req_ready_o`. Merge is tried first:
  - Merge target: the youngest PEND entry with equal word address and `nc = 0`, where the incoming `req_nc_i = 0`.
  - The entry at `iss_ptr` is not a target while `mem_valid_o = 1`.
  - On merge: entry data is replaced on lanes where `req_be_i` is set, and entry `be |= req_be_i`. `wr_ptr` is unchanged.
  - Otherwise a new entry is allocated at `wr_ptr` (state PEND) and `wr_ptr` increments.
- Issue:
  - `mem_valid_o = 1` when the `iss_ptr` entry is PEND and at least one ID is free in the registered free mask.
  - `mem_tid_o` is the lowest free ID.
  - On `mem_valid_o && mem_ready_i`: the entry goes to INFL, the ID is recorded and marked busy, and `iss_ptr` increments.
  - Address, data, be and tid stay stable while `mem_valid_o = 1` and `mem_ready_i = 0`.
- Acknowledge:
  - `ack_valid_i` with an ID held by an INFL entry moves that entry to DONE and frees the ID.
  - A freed ID is usable from the next cycle, not the same cycle.
  - Acks for IDs not in flight are ignored with no state change.
  - Acks may arrive out of order.
- Retire: each cycle, if the `ret_ptr` entry is DONE, it becomes FREE and `ret_ptr` increments. At most one entry retires per cycle.
- Load check: `ld_hit_o` is combinational; it is 1 when any PEND/INFL/DONE entry matches `ld_addr_i[PLEN-1:log2(XLEN/8)]`.

## Timing
- Reset values: `mem_valid_o=0`, `mem_addr_o=0`, `mem_data_o=0`, `mem_be_o=0`, `mem_tid_o=0`, `req_ready_o=1`, `empty_o=1`, `ld_hit_o=0`. All entries FREE, pointers 0, all IDs free.
- Latency: a store accepted in cycle N into an empty buffer presents `mem_valid_o=1` in cycle N+1.
- A store accepted in cycle N is visible to `ld_hit_o` in cycle N+1.
- Ack in cycle N for the oldest entry: `count` decrements in cycle N+2 (DONE at N+1, retire at N+1 edge).
- Simultaneous accept, issue, ack and retire in one cycle are all permitted and independent.
- When full (`count = DEPTH`), `req_ready_o = 0` and no merge is taken.
- When all 2^`TID_W` IDs are busy, `mem_valid_o = 0`.
- Pointer wrap-around is modulo `DEPTH` on the index bits.
- Reset mid-operation discards all entries and in-flight IDs immediately. Acks arriving after reset are ignored.

## Test plan
- Single store to 0x8000_0010, be=4'hF, data 0xDEADBEEF, `mem_ready_i=1` → `mem_valid_o` in the next cycle with addr 0x8000_0010 and tid 0. Ack tid 0 → `empty_o=1` two cycles later.
- Hold `mem_ready_i=0`, then store 0x8000_0020 be=4'h1 data 0x11 followed by 0x8000_0020 be=4'h2 data 0x2200:
  - The second store must not merge into the offered head, so `count=2`.
  - Then store 0x8000_0020 be=4'h4 → merges into entry 1, giving be=4'h6 and data 0x0022_2200 pattern.
- Fill 8 distinct stores with `mem_ready_i=0` → `req_ready_o=0` at `count=8`. A ninth request is not accepted and issues nothing.
- Four issues with no acks → tids 0,1,2,3, then `mem_valid_o=0`. Ack tid 2 → tid 2 is reissued no earlier than the following cycle. No retire happens until tid 0 acks.
- Two `nc=1` stores to the same word → two separate entries and two memory writes.
- Assert `rst_i` with 3 INFL entries, then ack tid 1 → ignored, `empty_o=1`, `ld_hit_o=0`.

Source files
------------

// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: merges word stores, issues to memory in order with
// per-write transaction IDs, and retires in order once acknowledged.
module wt_store_wbuf #(
  parameter int DEPTH = 8,
  parameter int PLEN  = 34,
  parameter int XLEN  = 32,
  parameter int TID_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [PLEN-1:0]      req_addr_i,
  input  logic [XLEN-1:0]      req_data_i,
  input  logic [XLEN/8-1:0]    req_be_i,
  input  logic                 req_nc_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [PLEN-1:0]      mem_addr_o,
  output logic [XLEN-1:0]      mem_data_o,
  output logic [XLEN/8-1:0]    mem_be_o,
  output logic [TID_W-1:0]     mem_tid_o,
  input  logic                 ack_valid_i,
  input  logic [TID_W-1:0]     ack_tid_i,
  input  logic [PLEN-1:0]      ld_addr_i,
  output logic                 ld_hit_o,
  output logic                 empty_o
);

  localparam int BW  = XLEN / 8;
  localparam int OFF = $clog2(BW);
  localparam int AW  = $clog2(DEPTH);
  localparam int WA  = PLEN - OFF;
  localparam int NID = 1 << TID_W;

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_INFL, ST_DONE} state_e;

  state_e           r_state [DEPTH];
  logic [WA-1:0]    r_addr  [DEPTH];
  logic [XLEN-1:0]  r_data  [DEPTH];
  logic [BW-1:0]    r_be    [DEPTH];
  logic             r_nc    [DEPTH];
  logic [TID_W-1:0] r_tid   [DEPTH];

  logic [AW:0]      r_wr_ptr, r_iss_ptr, r_ret_ptr;
  logic [NID-1:0]   r_tid_free;
  logic             r_hold;
  logic [TID_W-1:0] r_hold_tid;

  logic [AW:0]      w_count;
  logic [AW-1:0]    w_wr_idx, w_iss_idx, w_ret_idx;
  logic [WA-1:0]    w_req_waddr, w_ld_waddr;
  logic             w_accept, w_merge_hit, w_do_merge, w_alloc, w_issue;
  logic [AW-1:0]    w_merge_idx, w_scan_idx, w_ack_idx;
  logic             w_ack_hit, w_any_free, w_mem_valid, w_ld_hit;
  logic [TID_W-1:0] w_free_tid, w_tid_sel;
  logic [XLEN-1:0]  w_lane_mask, w_merged;
  logic             w_unused;

  assign w_count     = r_wr_ptr - r_ret_ptr;
  assign w_wr_idx    = r_wr_ptr[AW-1:0];
  assign w_iss_idx   = r_iss_ptr[AW-1:0];
  assign w_ret_idx   = r_ret_ptr[AW-1:0];
  assign w_req_waddr = req_addr_i[PLEN-1:OFF];
  assign w_ld_waddr  = ld_addr_i[PLEN-1:OFF];
  assign w_unused    = ^{req_addr_i[OFF-1:0], ld_addr_i[OFF-1:0]};

  assign req_ready_o = (w_count < (AW+1)'(DEPTH));
  assign empty_o     = (w_count == '0);
  assign w_accept    = req_valid_i && req_ready_o;

  assign w_any_free  = |r_tid_free;
  assign w_mem_valid = (r_state[w_iss_idx] == ST_PEND) && w_any_free;
  assign w_issue     = w_mem_valid && mem_ready_i;
  // A stalled offer keeps its ID even if a lower one frees up meanwhile.
  assign w_tid_sel   = r_hold ? r_hold_tid : w_free_tid;

  assign mem_valid_o = w_mem_valid;
  assign mem_addr_o  = w_mem_valid ? {r_addr[w_iss_idx], {OFF{1'b0}}} : '0;
  assign mem_data_o  = w_mem_valid ? r_data[w_iss_idx] : '0;
  assign mem_be_o    = w_mem_valid ? r_be[w_iss_idx] : '0;
  assign mem_tid_o   = w_mem_valid ? w_tid_sel : '0;
  assign ld_hit_o    = w_ld_hit;

  // Scan oldest to youngest so the last match is the youngest PEND entry.
  always_comb begin
    w_merge_hit = 1'b0;
    w_merge_idx = '0;
    w_scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = w_ret_idx + AW'(i);
      if (r_state[w_scan_idx] == ST_PEND && !r_nc[w_scan_idx] &&
          r_addr[w_scan_idx] == w_req_waddr &&
          !(w_mem_valid && w_scan_idx == w_iss_idx)) begin
        w_merge_hit = 1'b1;
        w_merge_idx = w_scan_idx;
      end
    end
  end

  assign w_do_merge = w_accept && !req_nc_i && w_merge_hit;
  assign w_alloc    = w_accept && !w_do_merge;

  always_comb begin
    w_lane_mask = '0;
    for (int b = 0; b < BW; b++) begin
      w_lane_mask[8*b +: 8] = {8{req_be_i[b]}};
    end
    w_merged = (r_data[w_merge_idx] & ~w_lane_mask) | (req_data_i & w_lane_mask);
  end

  always_comb begin
    w_free_tid = '0;
    for (int i = NID-1; i >= 0; i--) begin
      if (r_tid_free[i]) w_free_tid = TID_W'(i);
    end
  end

  always_comb begin
    w_ack_hit = 1'b0;
    w_ack_idx = '0;
    w_ld_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ack_valid_i && r_state[i] == ST_INFL && r_tid[i] == ack_tid_i) begin
        w_ack_hit = 1'b1;
        w_ack_idx = AW'(i);
      end
      if (r_state[i] != ST_FREE && r_addr[i] == w_ld_waddr) w_ld_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_FREE;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_be[i]    <= '0;
        r_nc[i]    <= 1'b0;
        r_tid[i]   <= '0;
      end
      r_wr_ptr   <= '0;
      r_iss_ptr  <= '0;
      r_ret_ptr  <= '0;
      r_tid_free <= '1;
      r_hold     <= 1'b0;
      r_hold_tid <= '0;
    end else begin
      if (w_do_merge) begin
        r_data[w_merge_idx] <= w_merged;
        r_be[w_merge_idx]   <= r_be[w_merge_idx] | req_be_i;
      end
      if (w_alloc) begin
        r_state[w_wr_idx] <= ST_PEND;
        r_addr[w_wr_idx]  <= w_req_waddr;
        r_data[w_wr_idx]  <= req_data_i;
        r_be[w_wr_idx]    <= req_be_i;
        r_nc[w_wr_idx]    <= req_nc_i;
        r_wr_ptr          <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_issue) begin
        r_state[w_iss_idx]    <= ST_INFL;
        r_tid[w_iss_idx]      <= w_tid_sel;
        r_tid_free[w_tid_sel] <= 1'b0;
        r_iss_ptr             <= r_iss_ptr + (AW+1)'(1);
      end
      if (w_ack_hit) begin
        r_state[w_ack_idx]    <= ST_DONE;
        r_tid_free[ack_tid_i] <= 1'b1;
      end
      if (r_state[w_ret_idx] == ST_DONE) begin
        r_state[w_ret_idx] <= ST_FREE;
        r_ret_ptr          <= r_ret_ptr + (AW+1)'(1);
      end
      r_hold     <= w_mem_valid && !mem_ready_i;
      r_hold_tid <= w_tid_sel;
    end
  end

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Scoreboard bench for wt_store_wbuf: expected memory writes are queued at store
// time and checked by a monitor at each accepted memory handshake.
module tb_wt_store_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_nc;
  logic [33:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        mem_valid, mem_ready;
  logic [33:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [1:0]  mem_tid;
  logic        ack_valid;
  logic [1:0]  ack_tid;
  logic [33:0] ld_addr;
  logic        ld_hit, empty;

  typedef struct {
    logic [33:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  tid;
    bit          chk_tid;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] infl_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  wt_store_wbuf #(.DEPTH(8), .PLEN(34), .XLEN(32), .TID_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be), .req_nc_i(req_nc),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_tid_o(mem_tid),
    .ack_valid_i(ack_valid), .ack_tid_i(ack_tid),
    .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .empty_o(empty)
  );

  // Scoreboard monitor: every accepted memory write pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mem_valid && mem_ready) begin
      infl_q.push_back(mem_tid);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%h data=%h be=%h tid=%0d, none expected",
                 mem_addr, mem_data, mem_be, mem_tid);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_data !== e.data || mem_be !== e.be ||
            (e.chk_tid && mem_tid !== e.tid)) begin
          n_err++;
          $display("FAIL mem_write: got addr=%h data=%h be=%h tid=%0d want addr=%h data=%h be=%h tid=%0d",
                   mem_addr, mem_data, mem_be, mem_tid, e.addr, e.data, e.be, e.tid);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [33:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic nc);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_be    = be;
    req_nc    = nc;
  endtask

  task automatic push_exp(input logic [33:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [1:0] tid, input bit chk);
    exp_t e;
    e.addr = a; e.data = d; e.be = be; e.tid = tid; e.chk_tid = chk;
    exp_q.push_back(e);
  endtask

  task automatic ack_once(input logic [1:0] t);
    ack_valid = 1'b1;
    ack_tid   = t;
    for (int i = 0; i < infl_q.size(); i++) begin
      if (infl_q[i] == t) begin
        infl_q.delete(i);
        break;
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    while (guard < 400 && !(empty && exp_q.size() == 0 && infl_q.size() == 0)) begin
      tick();
      if (infl_q.size() > 0) begin
        ack_valid = 1'b1;
        ack_tid   = infl_q.pop_front();
      end else begin
        ack_valid = 1'b0;
      end
      guard++;
    end
    ack_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got empty=%b pending=%0d want empty=1 pending=0", empty, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_be = '0; req_nc = 1'b0;
    mem_ready = 1'b0; ack_valid = 1'b0; ack_tid = '0; ld_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    n_cmp++; if (mem_addr !== 34'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_data !== 32'h0) begin n_err++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
    n_cmp++; if (mem_be !== 4'h0) begin n_err++; $display("FAIL rst_mem_be: got %h want 0", mem_be); end
    n_cmp++; if (mem_tid !== 2'd0) begin n_err++; $display("FAIL rst_mem_tid: got %0d want 0", mem_tid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (ld_hit !== 1'b0) begin n_err++; $display("FAIL rst_ld_hit: got %b want 0", ld_hit); end
  endtask

  task automatic test_single();
    tick();
    mem_ready = 1'b1;
    ld_addr   = 34'h0_8000_0013;
    push_exp(34'h0_8000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0, 1'b1);
    set_req(34'h0_8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    @(negedge clk);
    n_cmp++; if (ld_hit !== 1'b0) begin n_err++; $display("FAIL single_hit_early: got %b want 0", ld_hit); end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: got %b want 1", mem_valid); end
    n_cmp++; if (ld_hit !== 1'b1) begin n_err++; $display("FAIL single_hit: got %b want 1", ld_hit); end
    tick();
    ack_once(2'd0);
    @(negedge clk);
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty_n: got %b want 0", empty); end
    tick();
    ack_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty_n1: got %b want 0", empty); end
    tick();
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty_n2: got %b want 1", empty); end
    n_cmp++; if (ld_hit !== 1'b0) begin n_err++; $display("FAIL single_hit_gone: got %b want 0", ld_hit); end
  endtask

  task automatic test_merge();
    tick();
    mem_ready = 1'b0;
    set_req(34'h0_8000_0020, 32'h0000_0011, 4'h1, 1'b0);
    tick();
    set_req(34'h0_8000_0020, 32'h0000_2200, 4'h2, 1'b0);
    tick();
    set_req(34'h0_8000_0020, 32'h0022_0000, 4'h4, 1'b0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_valid !== 1'b1 || mem_addr !== 34'h0_8000_0020 || mem_data !== 32'h11 ||
        mem_be !== 4'h1 || mem_tid !== 2'd0) begin
      n_err++;
      $display("FAIL merge_head_hold: got v=%b a=%h d=%h be=%h tid=%0d want v=1 a=080000020 d=00000011 be=1 tid=0",
               mem_valid, mem_addr, mem_data, mem_be, mem_tid);
    end
    push_exp(34'h0_8000_0020, 32'h0000_0011, 4'h1, 2'd0, 1'b1);
    push_exp(34'h0_8000_0020, 32'h0022_2200, 4'h6, 2'd1, 1'b1);
    drain();
  endtask

  task automatic test_full_and_tids();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] t;
      t = (i < 4) ? 2'(i) : ((i == 4) ? 2'd2 : 2'd0);
      set_req(34'h0_8000_0100 + 34'(4*i), 32'hA0 + 32'(i), 4'hF, 1'b0);
      push_exp(34'h0_8000_0100 + 34'(4*i), 32'hA0 + 32'(i), 4'hF, t, (i < 6));
      if (i == 7) begin
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_ready7: got %b want 1", req_ready); end
      end
      tick();
    end
    set_req(34'h0_8000_011C, 32'h0000_0BAD, 4'hF, 1'b0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready8: got %b want 0", req_ready); end
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready9: got %b want 0", req_ready); end
    repeat (4) tick();
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL tids_exhausted: got %b want 0", mem_valid); end
    tick();
    ack_once(2'd2);
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL tid_reuse_same_cycle: got %b want 0", mem_valid); end
    tick();
    ack_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_valid !== 1'b1 || mem_tid !== 2'd2) begin
      n_err++;
      $display("FAIL tid_reuse_next: got v=%b tid=%0d want v=1 tid=2", mem_valid, mem_tid);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL no_early_retire: got %b want 0", req_ready); end
    tick();
    ack_once(2'd0);
    tick();
    ack_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL retire_n1: got %b want 0", req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL retire_n2: got %b want 1", req_ready); end
    drain();
  endtask

  task automatic test_nc();
    tick();
    mem_ready = 1'b0;
    ld_addr   = 34'h0_8000_0300;
    set_req(34'h0_8000_0400, 32'h0000_1234, 4'hF, 1'b0);
    push_exp(34'h0_8000_0400, 32'h0000_1234, 4'hF, 2'd0, 1'b0);
    tick();
    set_req(34'h0_8000_0300, 32'h0000_00AA, 4'h1, 1'b1);
    push_exp(34'h0_8000_0300, 32'h0000_00AA, 4'h1, 2'd0, 1'b0);
    tick();
    set_req(34'h0_8000_0300, 32'h0000_BB00, 4'h2, 1'b1);
    push_exp(34'h0_8000_0300, 32'h0000_BB00, 4'h2, 2'd0, 1'b0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (ld_hit !== 1'b1) begin n_err++; $display("FAIL nc_ld_hit: got %b want 1", ld_hit); end
    drain();
  endtask

  task automatic test_back_to_back();
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    tick();
    mem_ready = 1'b1;
    while (sent < 12 && guard < 300) begin
      logic [33:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      a  = 34'h0_8000_1000 + 34'(16*sent);
      d  = $urandom();
      be = 4'($urandom_range(1, 15));
      set_req(a, d, be, 1'b0);
      if (req_ready) begin
        push_exp(a, d, be, 2'd0, 1'b0);
        sent++;
      end
      if (infl_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        ack_valid = 1'b1;
        ack_tid   = infl_q.pop_front();
      end else begin
        ack_valid = 1'b0;
      end
      tick();
      guard++;
    end
    req_valid = 1'b0;
    ack_valid = 1'b0;
    n_cmp++; if (sent != 12) begin n_err++; $display("FAIL b2b_sent: got %0d want 12", sent); end
    drain();
  endtask

  task automatic test_reset_mid();
    tick();
    mem_ready = 1'b1;
    ld_addr   = 34'h0_8000_2004;
    for (int i = 0; i < 3; i++) begin
      set_req(34'h0_8000_2000 + 34'(4*i), 32'(i + 1), 4'hF, 1'b0);
      push_exp(34'h0_8000_2000 + 34'(4*i), 32'(i + 1), 4'hF, 2'(i), 1'b1);
      tick();
    end
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (ld_hit !== 1'b1) begin n_err++; $display("FAIL pre_rst_hit: got %b want 1", ld_hit); end
    tick();
    rst = 1'b1;
    infl_q.delete();
    tick();
    rst = 1'b0;
    ack_valid = 1'b1;
    ack_tid   = 2'd1;
    tick();
    ack_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
    n_cmp++; if (ld_hit !== 1'b0) begin n_err++; $display("FAIL rst_mid_hit: got %b want 0", ld_hit); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", mem_valid); end
    tick();
    set_req(34'h0_8000_2008, 32'h0000_0077, 4'hF, 1'b0);
    push_exp(34'h0_8000_2008, 32'h0000_0077, 4'hF, 2'd0, 1'b1);
    tick();
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_merge();
    test_full_and_tids();
    test_nc();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
